// File: rtl/param_bank_pkg.sv
// Shared constants and types for the channel parameter bank.
// Field codes, geometry and FSM state encoding.
package param_bank_pkg;

  localparam int NCHAN = 64;
  localparam int W     = 16;
  localparam int CW    = 6;

  localparam logic [1:0] FIELD_AMP    = 2'd0;
  localparam logic [1:0] FIELD_OFFSET = 2'd1;
  localparam logic [1:0] FIELD_PHASE  = 2'd2;
  localparam logic [1:0] FIELD_ILL    = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/param_field_bank.sv
// One field's shadow/active storage for all channels.
// Commit copies the post-edge shadow so same-cycle writes/clears land.
module param_field_bank
  import param_bank_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic [CW-1:0]        i_wchan,
  input  logic [W-1:0]         i_wdata,
  input  logic                 i_clr,
  input  logic [CW-1:0]        i_clr_chan,
  input  logic                 i_commit,
  output logic [NCHAN*W-1:0]   o_active
);

  logic [W-1:0]       r_shadow [NCHAN];
  logic [W-1:0]       w_next   [NCHAN];
  logic [NCHAN*W-1:0] w_next_flat;
  logic [NCHAN*W-1:0] r_active;

  always_comb begin
    w_next_flat = '0;
    for (int i = 0; i < NCHAN; i++) begin
      w_next[i] = r_shadow[i];
      if (i_we && i_wchan == CW'(i))
        w_next[i] = i_wdata;
      if (i_clr && i_clr_chan == CW'(i))
        w_next[i] = '0;
      w_next_flat[W*i +: W] = w_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCHAN; i++)
        r_shadow[i] <= '0;
      r_active <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++)
        r_shadow[i] <= w_next[i];
      if (i_commit)
        r_active <= w_next_flat;
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/channel_param_bank.sv
// Per-channel amp/offset/phase store with atomic shadow->active
// commit and a one-channel-per-cycle clear sweep.
module channel_param_bank
  import param_bank_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [CW-1:0]      wr_chan,
  input  logic [1:0]         wr_field,
  input  logic [W-1:0]       wr_data,
  input  logic               commit,
  input  logic               clear_req,
  output logic               commit_done,
  output logic               wr_err,
  output logic [NCHAN*W-1:0] amps,
  output logic [NCHAN*W-1:0] offsets,
  output logic [NCHAN*W-1:0] phasewords
);

  localparam logic [CW:0] LAST = (CW+1)'(NCHAN - 1);

  state_t      r_state, w_state_n;
  logic [CW:0] r_cnt, w_cnt_n;
  logic        r_pend, w_pend_n;
  logic        r_done;
  logic        r_err;

  logic w_acc;
  logic w_clr;
  logic w_last;
  logic w_commit;

  assign wr_ready = !reset && (r_state == ST_IDLE);
  assign w_acc    = wr_valid && wr_ready;
  assign w_clr    = (r_state == ST_CLEAR);
  assign w_last   = w_clr && (r_cnt == LAST);
  // A pending commit fires on the final sweep edge so it sees all-zero
  assign w_commit = (r_state == ST_IDLE && commit)
                  || (w_last && (r_pend || commit));

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_pend_n  = r_pend;
    unique case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_n = ST_CLEAR;
          w_cnt_n   = '0;
        end
      end
      ST_CLEAR: begin
        w_cnt_n = r_cnt + 1'b1;
        if (commit)
          w_pend_n = 1'b1;
        if (w_last) begin
          w_state_n = ST_IDLE;
          w_pend_n  = 1'b0;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_pend  <= w_pend_n;
      r_done  <= w_commit;
      r_err   <= w_acc && (wr_field == FIELD_ILL);
    end
  end

  assign commit_done = r_done;
  assign wr_err      = r_err;

  param_field_bank u_amp (
    .clk        (clk),
    .reset      (reset),
    .i_we       (w_acc && wr_field == FIELD_AMP),
    .i_wchan    (wr_chan),
    .i_wdata    (wr_data),
    .i_clr      (w_clr),
    .i_clr_chan (r_cnt[CW-1:0]),
    .i_commit   (w_commit),
    .o_active   (amps)
  );

  param_field_bank u_off (
    .clk        (clk),
    .reset      (reset),
    .i_we       (w_acc && wr_field == FIELD_OFFSET),
    .i_wchan    (wr_chan),
    .i_wdata    (wr_data),
    .i_clr      (w_clr),
    .i_clr_chan (r_cnt[CW-1:0]),
    .i_commit   (w_commit),
    .o_active   (offsets)
  );

  param_field_bank u_phs (
    .clk        (clk),
    .reset      (reset),
    .i_we       (w_acc && wr_field == FIELD_PHASE),
    .i_wchan    (wr_chan),
    .i_wdata    (wr_data),
    .i_clr      (w_clr),
    .i_clr_chan (r_cnt[CW-1:0]),
    .i_commit   (w_commit),
    .o_active   (phasewords)
  );

endmodule

// File: tb/tb_channel_param_bank.sv
// Directed bench for channel_param_bank with a commit scoreboard.
// Expected buses come from a shadow/active model kept in the bench.
module tb_channel_param_bank;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [5:0]    wr_chan = '0;
  logic [1:0]    wr_field = '0;
  logic [15:0]   wr_data = '0;
  logic          commit = 1'b0;
  logic          clear_req = 1'b0;
  logic          commit_done;
  logic          wr_err;
  logic [1023:0] amps;
  logic [1023:0] offsets;
  logic [1023:0] phasewords;

  typedef struct {
    logic [1023:0] a;
    logic [1023:0] o;
    logic [1023:0] p;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_sh  [3][64];
  logic [15:0] m_act [3][64];
  int          n_pass = 0;
  int          n_tot  = 0;

  channel_param_bank dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_chan     (wr_chan),
    .wr_field    (wr_field),
    .wr_data     (wr_data),
    .commit      (commit),
    .clear_req   (clear_req),
    .commit_done (commit_done),
    .wr_err      (wr_err),
    .amps        (amps),
    .offsets     (offsets),
    .phasewords  (phasewords)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] pk(input bit act, input int f);
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      r[i*16 +: 16] = act ? m_act[f][i] : m_sh[f][i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [1023:0] obs,
                     input logic [1023:0] exp);
    int ch;
    ch = 0;
    for (int i = 63; i >= 0; i--)
      if (obs[i*16 +: 16] !== exp[i*16 +: 16]) ch = i;
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: ch%0d got %h want %h", tag, ch,
                obs[ch*16 +: 16], exp[ch*16 +: 16]);
  endtask

  task automatic model_zero_shadow();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 64; i++) m_sh[f][i] = '0;
  endtask

  task automatic model_zero_all();
    model_zero_shadow();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 64; i++) m_act[f][i] = '0;
  endtask

  task automatic push_commit();
    exp_t e;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 64; i++) m_act[f][i] = m_sh[f][i];
    e.a = pk(1, 0);
    e.o = pk(1, 1);
    e.p = pk(1, 2);
    q.push_back(e);
  endtask

  task automatic do_write(input int ch, input int f, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_chan  = 6'(ch);
    wr_field = 2'(f);
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    if (f < 3) m_sh[f][ch] = d;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int   c;
    exp_t e;
    c = 0;
    while (commit_done !== 1'b1 && c < maxc) begin
      tick();
      c++;
    end
    chk({tag, "_done"}, 1024'(commit_done), 1024'(1));
    chk({tag, "_sbq"}, 1024'(q.size()), 1024'(1));
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_amps"}, amps, e.a);
      chk({tag, "_offs"}, offsets, e.o);
      chk({tag, "_phs"}, phasewords, e.p);
    end
  endtask

  task automatic do_commit(input string tag);
    commit = 1'b1;
    push_commit();
    tick();
    commit = 1'b0;
    wait_done(tag, 4);
    tick();
    chk({tag, "_pulse"}, 1024'(commit_done), 1024'(0));
  endtask

  initial begin
    int cnt;
    model_zero_all();

    tick();
    chk("rst_ready", 1024'(wr_ready), 1024'(0));
    tick();
    reset = 1'b0;
    #1;
    chk("ready", 1024'(wr_ready), 1024'(1));
    chk("rst_amps", amps, '0);
    chk("rst_offs", offsets, '0);
    chk("rst_phs", phasewords, '0);
    chk("rst_done", 1024'(commit_done), 1024'(0));

    do_write(5, 0, 16'h8001);
    chk("t1_err", 1024'(wr_err), 1024'(0));
    for (int i = 0; i < 10; i++) begin
      chk("t1_hold", amps, pk(1, 0));
      tick();
    end

    do_write(63, 1, 16'h00FF);
    do_write(0, 2, 16'h0400);
    do_commit("t2");
    chk("t2_a5", 1024'(amps[95:80]), 1024'(16'h8001));
    chk("t2_o63", 1024'(offsets[1023:1008]), 1024'(16'h00FF));
    chk("t2_p0", 1024'(phasewords[15:0]), 1024'(16'h0400));

    wr_valid = 1'b1;
    wr_chan  = 6'd10;
    wr_field = 2'd2;
    wr_data  = 16'h1234;
    commit   = 1'b1;
    m_sh[2][10] = 16'h1234;
    push_commit();
    tick();
    wr_valid = 1'b0;
    commit   = 1'b0;
    wait_done("t3", 4);
    chk("t3_p10", 1024'(phasewords[175:160]), 1024'(16'h1234));
    tick();

    for (int ch = 0; ch < 64; ch++)
      for (int f = 0; f < 3; f++)
        do_write(ch, f, 16'($urandom_range(1, 65535)));
    do_commit("t4fill");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    model_zero_shadow();
    cnt = 0;
    while (wr_ready === 1'b0 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("t4_sweep_len", 1024'(cnt), 1024'(64));
    chk("t4_hold_amps", amps, pk(1, 0));
    chk("t4_hold_offs", offsets, pk(1, 1));
    chk("t4_hold_phs", phasewords, pk(1, 2));
    do_commit("t4zero");
    chk("t4_zero", amps | offsets | phasewords, '0);

    do_write(9, 0, 16'h5A5A);
    do_write(40, 2, 16'hC3C3);
    do_commit("t5fill");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    model_zero_shadow();
    for (int i = 0; i < 20; i++) tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("t5_pend_hold", amps, pk(1, 0));
    push_commit();
    wait_done("t5", 100);
    chk("t5_ready", 1024'(wr_ready), 1024'(1));
    chk("t5_zero", amps | offsets | phasewords, '0);
    tick();

    do_write(3, 0, 16'h7777);
    do_commit("t5rfill");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 29; i++) tick();
    reset = 1'b1;
    tick();
    chk("t5_rst_ready", 1024'(wr_ready), 1024'(0));
    reset = 1'b0;
    #1;
    model_zero_all();
    chk("t5_idle", 1024'(wr_ready), 1024'(1));
    chk("t5_rst_buses", amps | offsets | phasewords, '0);

    do_write(7, 1, 16'h0011);
    do_commit("t6pre");
    chk("t6_ready", 1024'(wr_ready), 1024'(1));
    do_write(7, 3, 16'hFFFF);
    chk("t6_err", 1024'(wr_err), 1024'(1));
    tick();
    chk("t6_err_pulse", 1024'(wr_err), 1024'(0));
    do_commit("t6");

    chk("sb_empty", 1024'(q.size()), 1024'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
